// File: rtl/udm_uart_rx.sv
// 8N1 UART receiver (optional even parity via UDM_RX_PARITY_EN), two-flop input synchronizer,
// mid-bit sampling from a 16-bit bit-timing counter; good bytes leave with a one-cycle done tick.
module udm_uart_rx #(
    parameter int BAUD_DIVIDER = 87
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic       rx_done_tick_o,
    output logic [7:0] rx_dout_bo,
    output logic       frame_err_o,
    output logic       rx_busy_o
);

    localparam logic [15:0] HALF_M1 = 16'(BAUD_DIVIDER / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(BAUD_DIVIDER - 1);

`ifdef UDM_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q;
    logic [15:0] tcnt_q, tcnt_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  dout_q, dout_d;
    logic        tick_q, tick_d;
    logic        ferr_q, ferr_d;
    logic        frame_ok;

`ifdef UDM_RX_PARITY_EN
    logic        perr_q, perr_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) perr_q <= 1'b0;
        else         perr_q <= perr_d;
    end

    // A parity failure already raised the error; the stop bit must stay silent.
    assign frame_ok = ~perr_q;
`else
    assign frame_ok = 1'b1;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            tcnt_q    <= 16'd0;
            bcnt_q    <= 3'd0;
            sh_q      <= 8'h00;
            dout_q    <= 8'h00;
            tick_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            bcnt_q    <= bcnt_d;
            sh_q      <= sh_d;
            dout_q    <= dout_d;
            tick_q    <= tick_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = 16'(tcnt_q + 16'd1);
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        dout_d  = dout_q;
        tick_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef UDM_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        case (state_q)
            IDLE: begin
                tcnt_d = 16'd0;
`ifdef UDM_RX_PARITY_EN
                perr_d = 1'b0;
`endif
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (tcnt_q == HALF_M1) begin
                    tcnt_d  = 16'd0;
                    bcnt_d  = 3'd0;
                    state_d = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tcnt_q == FULL_M1) begin
                    tcnt_d = 16'd0;
                    sh_d   = {rx_s_q, sh_q[7:1]};
                    if (bcnt_q == 3'd7) begin
`ifdef UDM_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bcnt_d = bcnt_q + 3'd1;
                    end
                end
            end
`ifdef UDM_RX_PARITY_EN
            PARITY: begin
                if (tcnt_q == FULL_M1) begin
                    tcnt_d  = 16'd0;
                    state_d = STOP;
                    if ((^sh_q) ^ rx_s_q) begin
                        ferr_d = 1'b1;
                        perr_d = 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                // Leaving at mid stop bit gives half a bit of margin for the next start edge.
                if (tcnt_q == FULL_M1) begin
                    tcnt_d = 16'd0;
                    if (rx_s_q) begin
                        state_d = IDLE;
                        if (frame_ok) begin
                            dout_d = sh_q;
                            tick_d = 1'b1;
                        end
                    end else begin
                        state_d = BREAK;
                        if (frame_ok) ferr_d = 1'b1;
                    end
                end
            end
            BREAK: begin
                tcnt_d = 16'd0;
                if (rx_s_q) state_d = IDLE;
            end
            default: begin
                tcnt_d  = 16'd0;
                state_d = IDLE;
            end
        endcase
    end

    assign rx_done_tick_o = tick_q;
    assign rx_dout_bo     = dout_q;
    assign frame_err_o    = ferr_q;
    assign rx_busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_udm_uart_rx.sv
// Bench for udm_uart_rx at BAUD_DIVIDER=8: vector table, hand-written corner sequences, random frames vs a frame-level model.
module tb_udm_uart_rx;

    localparam int BD = 8;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       rx_i = 1'b1;
    logic       rx_done_tick_o;
    logic [7:0] rx_dout_bo;
    logic       frame_err_o;
    logic       rx_busy_o;

    udm_uart_rx #(.BAUD_DIVIDER(BD)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .rx_i           (rx_i),
        .rx_done_tick_o (rx_done_tick_o),
        .rx_dout_bo     (rx_dout_bo),
        .frame_err_o    (frame_err_o),
        .rx_busy_o      (rx_busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int n_tick = 0;
    int n_err = 0;
    int n_both = 0;
    int n_unstable = 0;
    int tick_cyc = 0;
    logic [7:0] last_dout = 8'h00;
    logic [7:0] rcv_q[$];
    logic [7:0] exp_q[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (reset_i) begin
            last_dout = rx_dout_bo;
        end else begin
            if (rx_done_tick_o) begin
                n_tick++;
                rcv_q.push_back(rx_dout_bo);
                tick_cyc = cyc;
            end
            if (frame_err_o) n_err++;
            if (rx_done_tick_o && frame_err_o) n_both++;
            if (!rx_done_tick_o && rx_dout_bo != last_dout) n_unstable++;
            last_dout = rx_dout_bo;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        repeat (BD) @(negedge clk_i);
    endtask

    task automatic idle_bits(input int n);
        rx_i = 1'b1;
        repeat (n * BD) @(negedge clk_i);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bad);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UDM_RX_PARITY_EN
        send_bit((^d) ^ par_bad);
`else
        if (par_bad) $display("note: parity disabled, par_bad ignored");
`endif
        send_bit(stop_bit);
    endtask

    function automatic logic parity_enabled();
`ifdef UDM_RX_PARITY_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       par_bad;
        int         exp_tick;
        int         exp_err;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, e0, start_cyc, c;
        logic seen;
        logic [7:0] prev_byte;

        tbl[0] = '{8'hFF, 1'b1, 1'b0, 1, 0};
        tbl[1] = '{8'h00, 1'b1, 1'b0, 1, 0};
        tbl[2] = '{8'h80, 1'b1, 1'b0, 1, 0};
        tbl[3] = '{8'hC3, 1'b0, 1'b0, 0, 1};
        tbl[4] = '{8'h01, 1'b1, 1'b0, 1, 0};
        tbl[5] = '{8'h5A, 1'b1, 1'b0, 1, 0};

        // Reset state
        #1;
        chk("reset_tick", int'(rx_done_tick_o), 0);
        chk("reset_err", int'(frame_err_o), 0);
        chk("reset_dout", int'(rx_dout_bo), 0);
        chk("reset_busy", int'(rx_busy_o), 0);
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        idle_bits(2);

        // Single frame with latency measurement
        t0 = n_tick; e0 = n_err;
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle_bits(2);
        chk("t1_ticks", n_tick - t0, 1);
        chk("t1_errs", n_err - e0, 0);
        chk("t1_dout", int'(rx_dout_bo), 8'hA5);
        chk("t1_busy_after", int'(rx_busy_o), 0);
        checks++;
        if (tick_cyc - start_cyc < 2 + BD/2 + 9*BD || tick_cyc - start_cyc > 2 + BD/2 + 9*BD + 2) begin
            errors++;
            $display("FAIL t1_latency: got %0d cycles expected %0d +-1", tick_cyc - start_cyc, 2 + BD/2 + 9*BD + 1);
        end
        prev_byte = 8'hA5;

        // Vector table
        for (int i = 0; i < 6; i++) begin
            t0 = n_tick; e0 = n_err;
            send_frame(tbl[i].data, tbl[i].stop_bit, tbl[i].par_bad);
            idle_bits(2);
            chk($sformatf("tbl%0d_ticks", i), n_tick - t0, tbl[i].exp_tick);
            chk($sformatf("tbl%0d_errs", i), n_err - e0, tbl[i].exp_err);
            if (tbl[i].exp_tick != 0) prev_byte = tbl[i].data;
            chk($sformatf("tbl%0d_dout", i), int'(rx_dout_bo), int'(prev_byte));
        end

        // Start-bit glitch
        t0 = n_tick; e0 = n_err;
        rx_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rx_i = 1'b1;
        c = 0; seen = 1'b0;
        while (c < 12) begin
            @(negedge clk_i);
            c++;
            if (rx_busy_o) seen = 1'b1;
            else if (seen) break;
        end
        chk("t2_busy_seen", int'(seen), 1);
        checks++;
        if (c > BD/2 + 3) begin
            errors++;
            $display("FAIL t2_busy_release: got %0d cycles expected at most %0d", c, BD/2 + 3);
        end
        idle_bits(2);
        chk("t2_ticks", n_tick - t0, 0);
        chk("t2_errs", n_err - e0, 0);

        // Bad stop bit followed by a long break, then a good frame
        t0 = n_tick; e0 = n_err;
        send_frame(8'h3C, 1'b0, 1'b0);
        rx_i = 1'b0;
        repeat (20 * BD) @(negedge clk_i);
        idle_bits(2);
        chk("t3_errs", n_err - e0, 1);
        chk("t3_ticks", n_tick - t0, 0);
        chk("t3_dout_kept", int'(rx_dout_bo), int'(prev_byte));
        send_frame(8'h55, 1'b1, 1'b0);
        idle_bits(2);
        chk("t3_ticks2", n_tick - t0, 1);
        chk("t3_dout2", int'(rx_dout_bo), 8'h55);

        // Back-to-back frames, no idle bits
        rcv_q.delete();
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        send_frame(8'h00, 1'b1, 1'b0);
        idle_bits(2);
        chk("t4_count", rcv_q.size(), 3);
        if (rcv_q.size() == 3) begin
            chk("t4_b0", int'(rcv_q[0]), 8'h55);
            chk("t4_b1", int'(rcv_q[1]), 8'h5A);
            chk("t4_b2", int'(rcv_q[2]), 8'h00);
        end

        // Reset in the middle of the data bits
        t0 = n_tick;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        chk("t5_busy_before", int'(rx_busy_o), 1);
        #2 reset_i = 1'b1;
        #1;
        chk("t5_tick", int'(rx_done_tick_o), 0);
        chk("t5_err", int'(frame_err_o), 0);
        chk("t5_dout", int'(rx_dout_bo), 0);
        chk("t5_busy", int'(rx_busy_o), 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        idle_bits(2);
        chk("t5_no_abort_tick", n_tick - t0, 0);
        send_frame(8'h81, 1'b1, 1'b0);
        idle_bits(2);
        chk("t5_ticks", n_tick - t0, 1);
        chk("t5_dout2", int'(rx_dout_bo), 8'h81);

`ifdef UDM_RX_PARITY_EN
        t0 = n_tick; e0 = n_err;
        send_frame(8'h07, 1'b1, 1'b0);
        idle_bits(2);
        chk("t6_good_tick", n_tick - t0, 1);
        chk("t6_good_dout", int'(rx_dout_bo), 8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        idle_bits(2);
        chk("t6_bad_ticks", n_tick - t0, 1);
        chk("t6_bad_errs", n_err - e0, 1);
`endif

        // Random frames against the frame-level model
        rcv_q.delete();
        exp_q.delete();
        e0 = n_err;
        c = 0;
        for (int i = 0; i < 30; i++) begin
            logic [7:0] d;
            logic sb, pb;
            int gap;
            d   = 8'($urandom_range(0, 255));
            sb  = ($urandom_range(0, 5) != 0);
            pb  = parity_enabled() && ($urandom_range(0, 4) == 0);
            gap = sb ? $urandom_range(0, 2) : $urandom_range(1, 3);
            if (sb && !pb) exp_q.push_back(d);
            else c++;
            send_frame(d, sb, pb);
            if (gap > 0) idle_bits(gap);
        end
        idle_bits(3);
        chk("rnd_count", rcv_q.size(), exp_q.size());
        chk("rnd_errs", n_err - e0, c);
        for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++)
            chk($sformatf("rnd_byte%0d", i), int'(rcv_q[i]), int'(exp_q[i]));

        chk("never_tick_and_err", n_both, 0);
        chk("dout_stable", n_unstable, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/udm_uart_rx.md
Name: udm_uart_rx

Overview:
- UART receiver that sits directly upstream of the UDM controller.
- Samples the serial debug line and reassembles 8N1 frames (LSB first).
- Emits each received byte with a single-cycle done tick, which the controller consumes as its rx byte stream.
- Also flags framing errors and line-break conditions.

Parameters:
BAUD_DIVIDER, 87, clk_i cycles per bit period; legal range 4..65535; internal bit-timing counter is 16 bits.

Ports:
clk_i  input  1  system clock
reset_i  input  1  asynchronous, active-high reset
rx_i  input  1  asynchronous serial line, idle high
rx_done_tick_o  output  1  one-cycle pulse: rx_dout_bo holds a newly received good byte
rx_dout_bo  output  8  last correctly framed byte
frame_err_o  output  1  one-cycle pulse: stop bit (or parity, if enabled) sampled bad
rx_busy_o  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Interface (already decided): one clock, clk_i; reset_i is asynchronous and active-high.
- Reset:
  - Asserting reset_i immediately forces all outputs low, rx_dout_bo to 8'h00, FSM to IDLE and counters to 0.
  - Both synchronizer flops reset to 1.
  - Reset mid-frame aborts the frame with no tick and no error.
- Synchronizer: rx_i passes through 2 flops; all FSM logic uses only the synchronized value rx_s.
- Counters:
  - Bit-timing counter tcnt (16 bit), cleared on every state change.
  - Bit index bcnt (3 bit).
  - Shift register sh (8 bit).
- IDLE: when rx_s==0, go to START with tcnt=0.
- START:
  - Increment tcnt until tcnt == BAUD_DIVIDER/2 - 1 (integer division), then sample rx_s.
  - rx_s==0: go to DATA, bcnt=0.
  - rx_s==1: glitch; return to IDLE silently.
- DATA:
  - Increment until tcnt == BAUD_DIVIDER-1, then sample: sh <= {rx_s, sh[7:1]}.
  - bcnt==7: go to STOP (PARITY if enabled); else bcnt+1.
- STOP: at tcnt == BAUD_DIVIDER-1, sample rx_s.
  - rx_s==1: on the next edge rx_dout_bo <= sh and rx_done_tick_o=1 for exactly one cycle; go to IDLE.
  - rx_s==0: frame_err_o=1 for one cycle; rx_dout_bo unchanged; go to BREAK.
- BREAK: wait for rx_s==1, then go to IDLE. A low line never produces repeated errors or ticks.
- Back-to-back frames: IDLE is re-entered half a bit before the nominal stop-bit end, so a start bit immediately following a stop bit is always caught.
- Latency: rx_done_tick_o rises 2 (synchronizer) + BAUD_DIVIDER/2 + 9*BAUD_DIVIDER + 1 cycles after the rx_i falling edge of the start bit, ±1 cycle of input phase.
- rx_done_tick_o and frame_err_o are mutually exclusive and are never asserted in the same cycle.
- rx_dout_bo is stable between ticks.

Optional Feature:
- UDM_RX_PARITY_EN defined:
  - After DATA, the FSM enters PARITY and samples one extra bit (same timing rule as DATA).
  - Even parity is required: XOR of sh and the parity bit must equal 0.
  - Mismatch: frame_err_o pulse, byte discarded (no tick). The stop bit is still consumed: go to STOP, which then suppresses the tick and error if an error was already flagged. A bad stop still goes to BREAK.
- Undefined: no PARITY state, plain 8N1, no parity logic synthesized.

Test Plan:
1. BAUD_DIVIDER=8; send 0xA5, 8N1 -> exactly one rx_done_tick_o pulse, rx_dout_bo=8'hA5, frame_err_o never high, rx_busy_o low afterwards.
2. rx_i low for 2 cycles then high -> START rejects the glitch; no tick, no error; rx_busy_o back to 0 within BAUD_DIVIDER/2+3 cycles.
3. Send 0x3C with stop bit 0, then hold rx_i low for 20 bit times, then high and send 0x55 -> single frame_err_o pulse, rx_dout_bo stays at the previous value, then one tick with 8'h55.
4. Send 0x55, 0x5A, 0x00 back-to-back with zero idle bits -> three ticks carrying 8'h55, 8'h5A, 8'h00, in order.
5. Assert reset_i mid-DATA of 0xFF, release, send 0x81 -> outputs clear asynchronously, no tick for the aborted frame, then one tick with 8'h81.
6. (UDM_RX_PARITY_EN) send 0x07 with parity bit 1 (good), then 0x07 with parity bit 0 (bad) -> tick with 8'h07, then a frame_err_o pulse and no second tick.
